// File: rtl/module_period_meter_pkg.sv
// pkg_period_meter: shared state type and default sizing for the period meter
package pkg_period_meter;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } meter_state_t;

    localparam int DEF_WIDTH       = 24;
    localparam int DEF_TIMEOUT     = 16777215;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/module_period_meter_edge_sync.sv
// module_edge_sync: synchronizes an async input and emits registered rise/fall pulses
//   clk, rst (async, active-high)
//   async_in : asynchronous input level
//   rise_p   : one-cycle pulse, SYNC_STAGES+1 cycles after an input rise
//   fall_p   : one-cycle pulse, SYNC_STAGES+1 cycles after an input fall
module module_edge_sync
    import pkg_period_meter::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_p,
    output logic fall_p
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d, rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_p = rise_q;
    assign fall_p = fall_q;

endmodule

// File: rtl/module_period_meter.sv
// module_period_meter: measures period, high time and half-period of a square wave in clk cycles
//   clk, rst (async, active-high)
//   sig_in    : measured signal, asynchronous to clk
//   period    : cycles between the last two rising edges
//   high_time : cycles from the last measured rise to its fall
//   nciclos   : period >> 1
//   valid     : one-cycle pulse when the outputs update
//   timeout   : level, no rising edge within TIMEOUT_CYCLES
module module_period_meter
    import pkg_period_meter::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic [WIDTH-1:0] nciclos,
    output logic             valid,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(TIMEOUT_CYCLES);

    meter_state_t     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ht_cap_q, ht_cap_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic [WIDTH-1:0] nciclos_q, nciclos_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             rise_p, fall_p, sat;

    module_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(sig_in),
        .rise_p  (rise_p),
        .fall_p  (fall_p)
    );

    always_comb begin
        // a rise arriving on the saturation cycle still counts as a measurement
        sat         = (cnt_q == CNT_MAX) && !rise_p;
        cnt_d       = rise_p ? WIDTH'(1) : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
        state_d     = state_q;
        ht_cap_d    = ht_cap_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        nciclos_d   = nciclos_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE: state_d = rise_p ? HIGH : IDLE;
            HIGH: if (fall_p) begin
                ht_cap_d = cnt_q;
                state_d  = LOW;
            end
            LOW: if (rise_p) begin
                period_d    = cnt_q;
                nciclos_d   = cnt_q >> 1;
                high_time_d = ht_cap_q;
                valid_d     = 1'b1;
                timeout_d   = 1'b0;
                state_d     = HIGH;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && sat) begin
            state_d     = IDLE;
            timeout_d   = 1'b1;
            period_d    = '0;
            high_time_d = '0;
            nciclos_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ht_cap_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            nciclos_q   <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ht_cap_q    <= ht_cap_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            nciclos_q   <= nciclos_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign nciclos   = nciclos_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_module_period_meter.sv
// tb_module_period_meter: waveform-level reference model checks every cycle, plus table and corner sequences
module tb_module_period_meter;

    localparam int W   = 24;
    localparam int TO  = 1000;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sig_in = 1'b0;
    logic [W-1:0] period, high_time, nciclos;
    logic         valid, timeout;

    module_period_meter #(
        .WIDTH(W),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .period   (period),
        .high_time(high_time),
        .nciclos  (nciclos),
        .valid    (valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Edges as driven on sig_in, keyed by the cycle they were applied
    bit rise_ev[int];
    bit fall_ev[int];
    int rel_cyc = 0;

    // Reference model: works on waveform edges delayed by the fixed pipeline latency
    int           last_rise = -1;
    int           fall_since = -1;
    bit           active = 1'b0;
    logic [W-1:0] e_per = '0, e_ht = '0, e_nc = '0;
    bit           e_to = 1'b0, e_val = 1'b0;

    int           n_valid = 0;
    int           last_valid_cyc = -1;
    logic [W-1:0] lv_per = '0, lv_ht = '0, lv_nc = '0;

    initial begin
        forever begin
            int e;
            @(negedge clk);
            e = cyc - LAT;
            e_val = 1'b0;
            if (rst) begin
                last_rise = -1;
                fall_since = -1;
                active = 1'b0;
                e_per = '0; e_ht = '0; e_nc = '0; e_to = 1'b0;
            end else if (e >= rel_cyc) begin
                if (rise_ev.exists(e)) begin
                    if (active && fall_since >= 0) begin
                        e_val = 1'b1;
                        e_per = W'(e - last_rise);
                        e_ht  = W'(fall_since - last_rise);
                        e_nc  = W'((e - last_rise) / 2);
                        e_to  = 1'b0;
                    end
                    last_rise = e;
                    fall_since = -1;
                    active = 1'b1;
                end else if (active) begin
                    if (fall_ev.exists(e) && fall_since < 0) fall_since = e;
                    if (e - last_rise == TO) begin
                        active = 1'b0;
                        e_to = 1'b1;
                        e_per = '0; e_ht = '0; e_nc = '0;
                    end
                end
            end
            chk("valid", valid, e_val);
            chk("period", period, e_per);
            chk("high_time", high_time, e_ht);
            chk("nciclos", nciclos, e_nc);
            chk("timeout", timeout, e_to);
            if (valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
                lv_per = period;
                lv_ht = high_time;
                lv_nc = nciclos;
            end
        end
    end

    // Called at a negedge; leaves sig_in low after hi+lo cycles per pulse
    task automatic wave(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            sig_in = 1'b1;
            rise_ev[cyc] = 1'b1;
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            fall_ev[cyc] = 1'b1;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        if (sig_in) rise_ev[cyc] = 1'b1;
    endtask

    typedef struct {
        int hi, lo, n;
        int per, ht, nc;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int v0, t_cyc;
        tbl = '{
            '{10, 10, 6, 20, 10, 10},
            '{3, 7, 6, 10, 3, 5},
            '{25, 25, 4, 50, 25, 25},
            '{1, 1, 8, 2, 1, 1},
            '{1, 4, 6, 5, 1, 2},
            '{400, 600, 3, 1000, 400, 500}
        };

        // Reset held while sig_in toggles
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            sig_in = ~sig_in;
        end
        chk("rst_period", period, 0);
        chk("rst_valid", valid, 0);
        sig_in = 1'b0;
        release_rst();

        // Table of steady patterns, back to back
        for (int i = 0; i < 6; i++) begin
            v0 = n_valid;
            wave(tbl[i].hi, tbl[i].lo, tbl[i].n);
            repeat (6) @(negedge clk);
            chk("tbl_count", n_valid - v0, (i == 0) ? tbl[i].n - 1 : tbl[i].n);
            chk("tbl_period", lv_per, tbl[i].per);
            chk("tbl_high", lv_ht, tbl[i].ht);
            chk("tbl_nciclos", lv_nc, tbl[i].nc);
        end

        // Freeze low until timeout, then restart
        wave(10, 10, 3);
        t_cyc = -1;
        for (int k = 0; k < 1100 && t_cyc < 0; k++) begin
            @(negedge clk);
            if (timeout === 1'b1) t_cyc = cyc;
        end
        chk("timeout_seen", t_cyc >= 0, 1);
        chk("timeout_delay", t_cyc - last_valid_cyc, TO);
        chk("timeout_period", period, 0);
        v0 = n_valid;
        wave(10, 10, 1);
        chk("restart_first", n_valid - v0, 0);
        wave(12, 8, 1);
        repeat (6) @(negedge clk);
        chk("restart_count", n_valid - v0, 1);
        chk("restart_period", lv_per, 20);
        chk("restart_timeout", timeout, 0);

        // Asynchronous reset in the middle of a high phase
        wave(10, 10, 3);
        sig_in = 1'b1;
        rise_ev[cyc] = 1'b1;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_period", period, 0);
        chk("arst_high", high_time, 0);
        chk("arst_nciclos", nciclos, 0);
        chk("arst_timeout", timeout, 0);
        repeat (3) @(negedge clk);
        v0 = n_valid;
        release_rst();
        repeat (5) @(negedge clk);
        sig_in = 1'b0;
        fall_ev[cyc] = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_novalid", n_valid - v0, 0);
        wave(7, 8, 3);
        repeat (6) @(negedge clk);
        chk("arst_count", n_valid - v0, 3);
        chk("arst_lastper", lv_per, 15);

        // Random patterns, some with low phases near the timeout boundary
        for (int i = 0; i < 40; i++) begin
            int hi, lo;
            hi = int'($urandom_range(1, 40));
            lo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(990, 1010)) : int'($urandom_range(1, 40));
            wave(hi, lo, int'($urandom_range(1, 4)));
        end
        repeat (1100) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
